// File: rtl/fa4_serial_add_ctrl.sv
// fa4_serial_add_ctrl: adds two NIBBLES*4-bit operands one nibble per clock
// through a single 4-bit add, LSB nibble first, with valid/ready on both sides.
module fa4_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_s;
    logic            r_co;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      w_sum5;
    logic            w_last;
    logic            w_accept;
    logic [CW+1:0]   w_base;

    // Handshake flags come straight from the state register, never from inputs
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign s         = r_s;
    assign co        = r_co;

    // Operand regs shift right each RUN cycle, so the active nibble is always [3:0]
    assign w_sum5   = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
    assign w_last   = (r_cnt == CW'(NIBBLES - 1));
    assign w_accept = in_valid && in_ready;
    assign w_base   = {r_cnt, 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, add one nibble per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_s[w_base +: 4] <= w_sum5[3:0];
                    r_a              <= r_a >> 4;
                    r_b              <= r_b >> 4;
                    r_carry          <= w_sum5[4];
                    if (w_last) begin
                        r_co  <= w_sum5[4];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fa4_serial_add_ctrl.md
Name: fa4_serial_add_ctrl

Overview:
Sequencer that time-shares one 4-bit adder slice to add two NIBBLES*4-bit operands, one nibble per clock, LSB nibble first. The ripple carry is held in a register between nibbles. A valid/ready handshake is used on both the operand side and the result side. It sits between an operand producer and a result consumer wherever a full-width adder costs too much area; the slice is the team's fa4_mbit or an equivalent internal 4-bit add.

Parameters:
NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  W  operand a
b  input  W  operand b
ci  input  1  carry in for nibble 0
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
s  output  W  sum
co  output  1  carry out of the top nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, s=0, co=0, out_valid=0, busy=0, in_ready=1, carry reg=0, nibble counter=0, operand regs=0.
- in_ready, out_valid and busy are decoded from the state register only. There is no combinational path from any input to any output.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a_r<=a, b_r<=b, carry<=ci, cnt<=0, then go to RUN.
  - Otherwise stay in IDLE; a, b and ci are ignored.
- RUN, one nibble per cycle:
  - Compute {c_next, nib} = a_r[4*cnt+3:4*cnt] + b_r[4*cnt+3:4*cnt] + carry, a 5-bit result.
  - Write nib into sum reg bits [4*cnt+3:4*cnt], then carry<=c_next and cnt<=cnt+1.
  - When cnt==NIBBLES-1: co<=c_next, cnt<=0, go to DONE.
  - a, b, ci and in_valid are ignored while in RUN.
  - Equivalent shift-register implementation is allowed: shift a_r/b_r right by 4 and shift nib into the top of the sum reg.
- DONE:
  - out_valid=1; s and co are held stable.
  - On out_ready: go to IDLE (out_valid=0 on the next cycle).
  - If out_ready=0, hold indefinitely with no change to s or co.
- Latency: accept at edge k gives out_valid=1 from edge k+NIBBLES.
- Minimum period between accepts is NIBBLES+2 cycles. DONE→IDLE takes one cycle, and no accept happens in the same cycle as the result handshake.
- s and co keep the last result after DONE→IDLE until the next RUN overwrites s nibble by nibble. Consumers sample only when out_valid=1.
- Counter width is max(1, clog2(NIBBLES)). NIBBLES=1 means RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^W. co is the true carry out of a+b+ci, so {co,s} equals a+b+ci exactly.
- rst_n asserted in any state (mid-RUN included) aborts the operation immediately to the reset state. Partial sums are discarded and no out_valid is produced for the aborted operation.
- in_valid held high across DONE→IDLE is accepted on the first IDLE cycle.

Test Plan:
1. NIBBLES=4; a=0x1234, b=0x4321, ci=0, accept at edge k -> out_valid rises at edge k+4, s=0x5555, co=0; in_ready=0 for edges k+1..k+5.
2. NIBBLES=4; a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1 (carry ripples through all four nibbles); then a=0xFFFF, b=0xFFFF, ci=1 -> s=0xFFFF, co=1.
3. Backpressure: finish a=0x00F0+b=0x0010 (s=0x0100), hold out_ready=0 for 6 cycles while driving in_valid=1 with other operands -> s and co unchanged, out_valid=1, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, then the pending in_valid is accepted.
4. Reset mid-operation: drop rst_n asynchronously two cycles into RUN -> s=0, co=0, out_valid=0, busy=0 immediately; after release in_ready=1 and a fresh 0x0001+0x0001 gives s=0x0002.
5. NIBBLES=1; a=0xF, b=0x1, ci=0 -> out_valid one cycle after accept, s=0x0, co=1; back-to-back in_valid with out_ready=1 gives one accept every 3 cycles.
6. Randomised 1000 operations at NIBBLES=4 and NIBBLES=8, with random in_valid/out_ready -> every result equals a+b+ci, with none lost or duplicated.
